// File: rtl/dmem_if.sv
// dmem_if
//   Data-memory port bundle between the core's load/store path (master)
//   and a memory responder (slave).
//
//   addr        byte address of the access              (master -> slave)
//   memRead     load request                            (master -> slave)
//   memWrite    store request                           (master -> slave)
//   memMode     0 = word access, 1 = byte access        (master -> slave)
//   wrData      store data, byte stores use [7:0]       (master -> slave)
//   rdData      registered load data                    (slave -> master)
//   ready       responder is accepting requests         (slave -> master)
//   misalignErr sticky misaligned-access flag           (slave -> master)
interface dmem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  memRead;
    logic                  memWrite;
    logic                  memMode;
    logic [WORD_WIDTH-1:0] wrData;
    logic [WORD_WIDTH-1:0] rdData;
    logic                  ready;
    logic                  misalignErr;

    modport master (
        output addr, memRead, memWrite, memMode, wrData,
        input  rdData, ready, misalignErr
    );

    modport slave (
        input  addr, memRead, memWrite, memMode, wrData,
        output rdData, ready, misalignErr
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Synchronous data-memory responder for the core's load/store port.
//   Loads return registered data one cycle after the request; stores are
//   committed on the edge where they are sampled. After every reset the
//   storage is swept to zero before requests are accepted.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   dmem_if.slave: addr, memRead, memWrite, memMode, wrData in;
//           rdData, ready, misalignErr out
//
//   Build option:
//     DMEM_MISALIGN_TRAP_EN  when defined, word accesses with addr[1:0] != 0
//                            are dropped and raise sticky misalignErr; when
//                            undefined the low address bits are ignored for
//                            word accesses and misalignErr stays 0.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int WORD_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W:0]        clr_idx_q, clr_idx_d;
    logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;

    logic [WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;
    logic [WORD_WIDTH-1:0] mem_wdata;

    logic [IDX_W-1:0]      word_idx;
    logic [1:0]            lane;
    logic [4:0]            lane_bit;
    logic [WORD_WIDTH-1:0] cur_word;
    logic [WORD_WIDTH-1:0] store_word;
    logic [WORD_WIDTH-1:0] load_value;
    logic                  misaligned;

    // Address decode: upper bits beyond the storage are ignored, so the
    // address space wraps modulo 4*DEPTH_WORDS bytes.
    assign word_idx = bus.addr[2 +: IDX_W];
    assign lane     = bus.addr[1:0];
    assign lane_bit = {lane, 3'b000};
    assign cur_word = mem_q[word_idx];

    generate
        if (ADDR_WIDTH > IDX_W + 2) begin : g_unused_addr
            logic unused_addr_bits;
            assign unused_addr_bits = ^bus.addr[ADDR_WIDTH-1:IDX_W+2];
        end
    endgenerate

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = (bus.memRead || bus.memWrite) && !bus.memMode
                        && (lane != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Byte stores merge wrData[7:0] into the addressed lane of the current
    // word; word stores replace the whole word.
    always_comb begin
        store_word = cur_word;
        if (bus.memMode) begin
            store_word[lane_bit +: 8] = bus.wrData[7:0];
        end else begin
            store_word = bus.wrData;
        end
    end

    // Byte loads zero-extend the addressed lane.
    always_comb begin
        load_value = cur_word;
        if (bus.memMode) begin
            load_value = {{(WORD_WIDTH-8){1'b0}}, cur_word[lane_bit +: 8]};
        end
    end

    // Next-state logic. CLEAR writes one zero word per cycle; once the index
    // has passed the last word it spends one more cycle before IDLE. A store
    // that coincides with a load wins and the load is dropped.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_widx  = word_idx;
        mem_wdata = store_word;

        case (state_q)
            ST_CLEAR: begin
                rd_data_d = '0;
                if (clr_idx_q[IDX_W]) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_we    = 1'b1;
                    mem_widx  = clr_idx_q[IDX_W-1:0];
                    mem_wdata = '0;
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (misaligned) begin
                    err_d = 1'b1;
                end else if (bus.memWrite) begin
                    mem_we = 1'b1;
                end else if (bus.memRead) begin
                    rd_data_d = load_value;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            rd_data_q <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rd_data_q <= rd_data_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    // Storage array; contents are not reset, the sweep zeroes them instead.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    assign bus.rdData      = rd_data_q;
    assign bus.ready       = ready_q;
    assign bus.misalignErr = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int DEPTH      = 256;
   localparam int SWEEP_LOW  = DEPTH + 1;

   typedef struct {
      string       name;
      logic [31:0] addr;
      bit          rd;
      bit          wr;
      bit          mode;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] val;
   } sb_t;

   logic clk;
   logic rst;

   int checks   = 0;
   int failures = 0;

   sb_t  sbQueue[$];
   vec_t vecs[16];

   dmem_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) busIf ();

   dmem_responder #(
      .ADDR_WIDTH (32),
      .WORD_WIDTH (32),
      .DEPTH_WORDS(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(busIf.slave)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mkVec(string n, logic [31:0] a, bit r, bit w,
                                  bit m, logic [31:0] d, logic [31:0] e);
      vec_t v;
      v.name = n; v.addr = a; v.rd = r; v.wr = w; v.mode = m;
      v.wdata = d; v.exp = e;
      return v;
   endfunction

   // Single comparison with failure reporting.
   task automatic checkEq(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one request, record the expected rdData, advance one edge.
   task automatic applyStimulus(string name, logic [31:0] a, bit r, bit w,
                                bit m, logic [31:0] d, logic [31:0] e);
      sb_t s;
      busIf.addr     = a;
      busIf.memRead  = r;
      busIf.memWrite = w;
      busIf.memMode  = m;
      busIf.wrData   = d;
      s.name = name;
      s.val  = e;
      sbQueue.push_back(s);
      @(posedge clk);
      #1;
      busIf.memRead  = 1'b0;
      busIf.memWrite = 1'b0;
   endtask

   // Pop the oldest expectation and compare against rdData.
   task automatic checkOutput();
      sb_t s;
      if (sbQueue.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         s = sbQueue.pop_front();
         checkEq(s.name, busIf.rdData, s.val);
      end
   endtask

   task automatic runVec(vec_t v);
      applyStimulus(v.name, v.addr, v.rd, v.wr, v.mode, v.wdata, v.exp);
      checkOutput();
   endtask

   // One-cycle reset pulse; outputs sampled just after the reset edge.
   task automatic doReset();
      rst            = 1'b1;
      busIf.memRead  = 1'b0;
      busIf.memWrite = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Count edges (reset edge included) with ready low, while hammering the
   // responder with a store that the sweep must ignore.
   task automatic countSweep(string name);
      int cnt;
      cnt = 1;
      busIf.addr     = 32'h0000_0000;
      busIf.memMode  = 1'b0;
      busIf.wrData   = 32'hFFFF_FFFF;
      for (int e = 0; e < 400; e++) begin
         busIf.memWrite = (e >= 3);
         @(posedge clk);
         #1;
         if (busIf.ready) break;
         cnt++;
      end
      busIf.memWrite = 1'b0;
      busIf.memRead  = 1'b0;
      checkEq(name, cnt, SWEEP_LOW);
   endtask

   initial begin
      vecs[0]  = mkVec("ld_0x000",        32'h000, 1, 0, 0, 32'h0,        32'h0000_0000);
      vecs[1]  = mkVec("ld_0x3FC",        32'h3FC, 1, 0, 0, 32'h0,        32'h0000_0000);
      vecs[2]  = mkVec("ld_0x200",        32'h200, 1, 0, 0, 32'h0,        32'h0000_0000);
      vecs[3]  = mkVec("st_word_hold",    32'h010, 0, 1, 0, 32'hDEADBEEF, 32'h0000_0000);
      vecs[4]  = mkVec("ld_word_0x010",   32'h010, 1, 0, 0, 32'h0,        32'hDEADBEEF);
      vecs[5]  = mkVec("st_byte_hold",    32'h012, 0, 1, 1, 32'h0000_00AA, 32'hDEADBEEF);
      vecs[6]  = mkVec("ld_word_merged",  32'h010, 1, 0, 0, 32'h0,        32'hDEAABEEF);
      vecs[7]  = mkVec("ld_byte_0x013",   32'h013, 1, 0, 1, 32'h0,        32'h0000_00DE);
      vecs[8]  = mkVec("ld_byte_0x010",   32'h010, 1, 0, 1, 32'h0,        32'h0000_00EF);
      vecs[9]  = mkVec("st_word_0x080",   32'h080, 0, 1, 0, 32'h11111111, 32'h0000_00EF);
      vecs[10] = mkVec("ld_word_0x080",   32'h080, 1, 0, 0, 32'h0,        32'h11111111);
      vecs[11] = mkVec("rd_wr_both_hold", 32'h404, 1, 1, 0, 32'h12345678, 32'h11111111);
      vecs[12] = mkVec("idle_hold",       32'h000, 0, 0, 0, 32'h0,        32'h11111111);
      vecs[13] = mkVec("ld_wrap_0x004",   32'h004, 1, 0, 0, 32'h0,        32'h12345678);
      vecs[14] = mkVec("st_byte_upper",   32'h0C1, 0, 1, 1, 32'hFFFFFF55, 32'h12345678);
      vecs[15] = mkVec("ld_word_0x0C0",   32'h0C0, 1, 0, 0, 32'h0,        32'h0000_5500);

      rst            = 1'b0;
      busIf.addr     = '0;
      busIf.memRead  = 1'b0;
      busIf.memWrite = 1'b0;
      busIf.memMode  = 1'b0;
      busIf.wrData   = '0;
      @(posedge clk);
      #1;

      // Reset state and full sweep.
      doReset();
      checkEq("reset_ready",   {31'b0, busIf.ready}, 32'h0);
      checkEq("reset_rdData",  busIf.rdData, 32'h0);
      checkEq("reset_misalign", {31'b0, busIf.misalignErr}, 32'h0);
      countSweep("sweep_ready_low_edges");
      checkEq("sweep_rdData", busIf.rdData, 32'h0);

      // Main table of single-cycle requests.
      for (int i = 0; i < 16; i++) begin
         runVec(vecs[i]);
      end
      runVec(mkVec("ld_byte_0x0C1", 32'h0C1, 1, 0, 1, 32'h0, 32'h0000_0055));
      checkEq("aligned_misalign", {31'b0, busIf.misalignErr}, 32'h0);

      // Misaligned word store to 0x031.
      runVec(mkVec("st_misaligned_hold", 32'h031, 0, 1, 0, 32'h55555555, 32'h0000_0055));
`ifdef DMEM_MISALIGN_TRAP_EN
      checkEq("misalign_set", {31'b0, busIf.misalignErr}, 32'h1);
      runVec(mkVec("ld_after_misaligned", 32'h030, 1, 0, 0, 32'h0, 32'h0000_0000));
      checkEq("misalign_sticky", {31'b0, busIf.misalignErr}, 32'h1);
`else
      checkEq("misalign_tied", {31'b0, busIf.misalignErr}, 32'h0);
      runVec(mkVec("ld_after_misaligned", 32'h030, 1, 0, 0, 32'h0, 32'h55555555));
      checkEq("misalign_still_0", {31'b0, busIf.misalignErr}, 32'h0);
`endif

      // Reset in the middle of a sweep restarts it from scratch.
      runVec(mkVec("st_word_0x020", 32'h020, 0, 1, 0, 32'hCAFEF00D, busIf.rdData));
      runVec(mkVec("ld_word_0x020", 32'h020, 1, 0, 0, 32'h0, 32'hCAFEF00D));
      doReset();
      checkEq("rst2_rdData",   busIf.rdData, 32'h0);
      checkEq("rst2_misalign", {31'b0, busIf.misalignErr}, 32'h0);
      repeat (10) @(posedge clk);
      #1;
      doReset();
      checkEq("rst3_ready", {31'b0, busIf.ready}, 32'h0);
      countSweep("resweep_ready_low_edges");
      runVec(mkVec("ld_0x020_cleared", 32'h020, 1, 0, 0, 32'h0, 32'h0000_0000));
      runVec(mkVec("ld_0x000_cleared", 32'h000, 1, 0, 0, 32'h0, 32'h0000_0000));

      if (sbQueue.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sbQueue.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Synchronous data-memory responder answering the core's data-memory port (address, read/write strobes, word/byte mode). It returns load data one cycle after the request and commits stores on the request edge. After reset it clears its storage with a sweep state machine. It is the memory-side counterpart of the core's load/store path and replaces the behavioural memory in core-level benches.

## Interface
- `ADDR_WIDTH`, default 32: address width (matches `` `ADDR_WIDTH``).
- `WORD_WIDTH`, default 32: data width (matches `` `WORD_WIDTH``).
- `DEPTH_WORDS`, default 256: storage depth in words. Must be a power of two, at least 2.
- `clk`  in  1  clock; all logic acts on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `addr`  in  ADDR_WIDTH  byte address of the access.
- `memRead`  in  1  load request.
- `memWrite`  in  1  store request.
- `memMode`  in  1  0 = word access, 1 = byte access.
- `wrData`  in  WORD_WIDTH  store data; byte stores use bits [7:0].
- `rdData`  out  WORD_WIDTH  load data, registered.
- `ready`  out  1  high when requests are accepted (state IDLE).
- `misalignErr`  out  1  sticky misaligned-access flag (see Configuration).

## Operation
- Word index is `addr[2 +: log2(DEPTH_WORDS)]`. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS. Byte lane is `addr[1:0]`.
- FSM states:
  - CLEAR: entered on reset. Writes 0 to the word at `clrIdx`, then increments `clrIdx`. Goes to IDLE on the cycle after the write to index DEPTH_WORDS-1. All requests in CLEAR are ignored; `rdData` holds 0.
  - IDLE: serves requests. Stays in IDLE until the next `rst`.
- Store, word (`memMode`=0): the whole word is replaced by `wrData`.
- Store, byte (`memMode`=1): only lane `addr[1:0]` is replaced by `wrData[7:0]`; the other lanes are unchanged.
- Load, word: `rdData` = stored word.
- Load, byte: `rdData` = zero-extended lane `addr[1:0]`.
- No request (`memRead`=`memWrite`=0): `rdData` holds its last value.
- `memRead` and `memWrite` both high: the store is performed and the read is suppressed, so `rdData` holds.
- A load on the cycle after a store to the same word returns the newly written data.
- Reset during CLEAR or IDLE: returns to CLEAR with `clrIdx`=0 and restarts the full sweep.
- Reset values: `rdData`=0, `ready`=0, `misalignErr`=0, state CLEAR, `clrIdx`=0.

## Timing
- Load latency is 1 cycle. A request sampled at edge N has `rdData` valid after edge N.
- A store is committed at the edge where it is sampled.
- Clear sweep: `rst` sampled high at edge 0 puts the block in CLEAR. Sweep writes occur on edges 1 to DEPTH_WORDS, including for the last word. `ready` rises after edge DEPTH_WORDS+1. The first request is accepted at edge DEPTH_WORDS+2.
- One request per cycle, no back-pressure, no outstanding transactions.
- `ready` is a registered state decode. It has no combinational path from any input.

## Configuration
- Macro: `DMEM_MISALIGN_TRAP_EN`.
- Defined: a word access with `addr[1:0]`≠0 is misaligned. A misaligned store leaves memory unchanged. A misaligned load leaves `rdData` holding. In both cases `misalignErr` is set and stays set until `rst`. Byte accesses are never misaligned.
- Undefined: `addr[1:0]` is ignored for word accesses, which then act on the aligned word. `misalignErr` is tied to 0.

## Test plan
- Reset then clear, DEPTH_WORDS=256: assert `rst` for 1 cycle -> `ready` low for exactly 257 edges after the reset edge. Word loads from 0x000, 0x3FC and 0x200 then return 0x00000000.
- Word store then load: store 0xDEADBEEF at 0x010; load word 0x010 on the next cycle -> `rdData`=0xDEADBEEF one cycle after the load.
- Byte store and byte load: after the word store above, byte-store wrData=0x000000AA at 0x012 -> word load at 0x010 gives 0xDEAABEEF; byte load at 0x013 gives 0x000000DE.
- Simultaneous read and write plus address wrap: `rdData`=0x11111111 from a prior load; then both strobes high with word store 0x12345678 to 0x404 -> `rdData` stays 0x11111111 on the next cycle. A following word load at 0x004 returns 0x12345678.
- Reset mid-operation: store 0xCAFEF00D at 0x020, assert `rst` 10 cycles into the following sweep -> `ready` low for another 257 edges, and a load at 0x020 then returns 0.
- Misaligned word store 0x55555555 to 0x031, checked with and without `DMEM_MISALIGN_TRAP_EN`:
  - Defined: `misalignErr` rises after the edge and stays high; a word load at 0x030 returns 0.
  - Undefined: a word load at 0x030 returns 0x55555555 and `misalignErr` stays 0.
